// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor coordinate controller: FSM encoding,
// button indices and the helper that resolves simultaneous presses.
package cursor_pkg;

   localparam int NUM_BTN = 5;
   localparam int COORD_W = 3;

   localparam logic [2:0] BTN_CONF  = 3'd0;
   localparam logic [2:0] BTN_UP    = 3'd1;
   localparam logic [2:0] BTN_DOWN  = 3'd2;
   localparam logic [2:0] BTN_LEFT  = 3'd3;
   localparam logic [2:0] BTN_RIGHT = 3'd4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      ACT      = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   // Highest-priority pressed button: conf > up > down > left > right.
   // Only meaningful when at least one bit of pressed is set.
   function automatic logic [2:0] pick_btn(input logic [NUM_BTN-1:0] pressed);
      if (pressed[BTN_CONF])      return BTN_CONF;
      else if (pressed[BTN_UP])   return BTN_UP;
      else if (pressed[BTN_DOWN]) return BTN_DOWN;
      else if (pressed[BTN_LEFT]) return BTN_LEFT;
      else                        return BTN_RIGHT;
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous active-low button inputs.
// Resets to all ones so that every button reads as released.
module btn_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta;

   // Two register stages to resolve metastability on the raw pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         dout <= '1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/cursor_coord_ctrl.sv
// Converts five raw pushbuttons into a wrap-around cursor position
// (mdc = column, mdl = line) plus one-cycle move and confirm pulses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no button pressed; capture the highest-priority press
// DEBOUNCE | captured button must stay pressed for DEB_CYCLES cycles
// ACT      | one cycle: apply the captured action, fire its pulse
// WAIT_REL | all buttons must stay released for DEB_CYCLES cycles
module cursor_coord_ctrl
   import cursor_pkg::*;
#(
   parameter int COLS       = 4,
   parameter int ROWS       = 4,
   parameter int DEB_CYCLES = 500000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_up_n,
   input  logic               btn_down_n,
   input  logic               btn_left_n,
   input  logic               btn_right_n,
   input  logic               btn_conf_n,
   output logic [COORD_W-1:0] mdc,
   output logic [COORD_W-1:0] mdl,
   output logic               move_pulse,
   output logic               conf_pulse
);

   localparam int                  CNT_W    = $clog2(DEB_CYCLES) + 1;
   localparam logic [CNT_W-1:0]    DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [COORD_W-1:0]  COL_MAX  = COORD_W'(COLS - 1);
   localparam logic [COORD_W-1:0]  ROW_MAX  = COORD_W'(ROWS - 1);

   logic [NUM_BTN-1:0] btn_raw_n;
   logic [NUM_BTN-1:0] btn_sync_n;
   logic [NUM_BTN-1:0] pressed;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         cap;

   // Bit order follows the button index constants.
   assign btn_raw_n = {btn_right_n, btn_left_n, btn_down_n, btn_up_n, btn_conf_n};

   btn_sync #(
      .WIDTH (NUM_BTN)
   ) u_btn_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (btn_raw_n),
      .dout  (btn_sync_n)
   );

   assign pressed = ~btn_sync_n;

   // Sequencing FSM with registered cursor position and pulses.
   // The counter never passes DEB_LAST, so it cannot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cap        <= BTN_CONF;
         mdc        <= '0;
         mdl        <= '0;
         move_pulse <= 1'b0;
         conf_pulse <= 1'b0;
      end else begin
         move_pulse <= 1'b0;
         conf_pulse <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (|pressed) begin
                  cap   <= pick_btn(pressed);
                  state <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (!pressed[cap]) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt >= DEB_LAST) begin
                  cnt   <= '0;
                  state <= ACT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ACT: begin
               cnt   <= '0;
               state <= WAIT_REL;
               case (cap)
                  BTN_UP: begin
                     mdl        <= (mdl == '0) ? ROW_MAX : mdl - 1'b1;
                     move_pulse <= 1'b1;
                  end
                  BTN_DOWN: begin
                     mdl        <= (mdl == ROW_MAX) ? '0 : mdl + 1'b1;
                     move_pulse <= 1'b1;
                  end
                  BTN_LEFT: begin
                     mdc        <= (mdc == '0) ? COL_MAX : mdc - 1'b1;
                     move_pulse <= 1'b1;
                  end
                  BTN_RIGHT: begin
                     mdc        <= (mdc == COL_MAX) ? '0 : mdc + 1'b1;
                     move_pulse <= 1'b1;
                  end
                  BTN_CONF: begin
                     conf_pulse <= 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            WAIT_REL: begin
               if (|pressed) begin
                  cnt <= '0;
               end else if (cnt >= DEB_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cursor_coord_ctrl.sv
// Scoreboard bench for cursor_coord_ctrl with DEB_CYCLES=4, 4x4 grid.
// Each expected pulse (kind, coordinates, cycle) is queued at press time;
// a monitor pops and compares whenever a pulse appears.
module tb_cursor_coord_ctrl;

   localparam logic [4:0] M_CONF  = 5'b00001;
   localparam logic [4:0] M_UP    = 5'b00010;
   localparam logic [4:0] M_DOWN  = 5'b00100;
   localparam logic [4:0] M_LEFT  = 5'b01000;
   localparam logic [4:0] M_RIGHT = 5'b10000;

   typedef struct {
      logic       conf;
      logic [2:0] mdc;
      logic [2:0] mdl;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] btn_n = 5'b11111;
   logic [2:0] mdc;
   logic [2:0] mdl;
   logic       move_pulse;
   logic       conf_pulse;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   cursor_coord_ctrl #(
      .COLS       (4),
      .ROWS       (4),
      .DEB_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_up_n    (btn_n[1]),
      .btn_down_n  (btn_n[2]),
      .btn_left_n  (btn_n[3]),
      .btn_right_n (btn_n[4]),
      .btn_conf_n  (btn_n[0]),
      .mdc         (mdc),
      .mdl         (mdl),
      .move_pulse  (move_pulse),
      .conf_pulse  (conf_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      btn_n = 5'b11111;
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge. An accepted press shows its pulse 8 edges later.
   task automatic press(input logic [4:0] mask, input int hold, input bit expect_p,
                        input bit is_conf, input logic [2:0] emdc, input logic [2:0] emdl);
      exp_t e;
      btn_n = ~mask;
      if (expect_p) begin
         e.conf = is_conf;
         e.mdc  = emdc;
         e.mdl  = emdl;
         e.cyc  = cyc + 8;
         sb.push_back(e);
      end
      repeat (hold) @(negedge clk);
      btn_n = 5'b11111;
   endtask

   initial begin
      exp_t e;
      fork
         forever begin
            @(negedge clk);
            if (rst_n && (move_pulse || conf_pulse)) begin
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_pulse: got move=%0b conf=%0b mdc=%0d mdl=%0d at cyc %0d, expected no pulse",
                           move_pulse, conf_pulse, mdc, mdl, cyc);
               end else begin
                  e = sb.pop_front();
                  if ((move_pulse && conf_pulse) || (conf_pulse != e.conf) ||
                      (move_pulse == e.conf) || (mdc != e.mdc) || (mdl != e.mdl) ||
                      (cyc != e.cyc)) begin
                     miscompares++;
                     $display("FAIL pulse: got move=%0b conf=%0b mdc=%0d mdl=%0d cyc=%0d, expected conf=%0b mdc=%0d mdl=%0d cyc=%0d",
                              move_pulse, conf_pulse, mdc, mdl, cyc, e.conf, e.mdc, e.mdl, e.cyc);
                  end
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      check("reset_mdc", int'(mdc), 0);
      check("reset_mdl", int'(mdl), 0);
      check("reset_move", int'(move_pulse), 0);
      check("reset_conf", int'(conf_pulse), 0);

      // Right x4 wraps the column.
      press(M_RIGHT, 20, 1'b1, 1'b0, 3'd1, 3'd0); idle(10);
      press(M_RIGHT, 20, 1'b1, 1'b0, 3'd2, 3'd0); idle(10);
      press(M_RIGHT, 20, 1'b1, 1'b0, 3'd3, 3'd0); idle(10);
      press(M_RIGHT, 20, 1'b1, 1'b0, 3'd0, 3'd0); idle(10);

      // Move away from 0, then reset asynchronously mid-debounce.
      press(M_RIGHT, 20, 1'b1, 1'b0, 3'd1, 3'd0); idle(10);
      btn_n = ~M_RIGHT;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mdc", int'(mdc), 0);
      check("async_rst_mdl", int'(mdl), 0);
      check("async_rst_move", int'(move_pulse), 0);
      check("async_rst_conf", int'(conf_pulse), 0);
      btn_n = 5'b11111;
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      check("post_rst_mdc", int'(mdc), 0);

      // Line wrap upward, then down twice.
      press(M_UP,   20, 1'b1, 1'b0, 3'd0, 3'd3); idle(10);
      press(M_DOWN, 20, 1'b1, 1'b0, 3'd0, 3'd0); idle(10);
      press(M_DOWN, 20, 1'b1, 1'b0, 3'd0, 3'd1); idle(10);

      // Bouncing right press must be rejected.
      btn_n = ~M_RIGHT; repeat (2) @(negedge clk);
      btn_n = 5'b11111; @(negedge clk);
      btn_n = ~M_RIGHT; repeat (2) @(negedge clk);
      idle(20);
      check("bounce_mdc", int'(mdc), 0);
      check("bounce_mdl", int'(mdl), 1);
      press(M_RIGHT, 8, 1'b1, 1'b0, 3'd1, 3'd1); idle(10);

      // Conf wins over left; held buttons and a short release do not repeat.
      press(M_CONF | M_LEFT, 50, 1'b1, 1'b1, 3'd1, 3'd1); idle(3);
      press(M_LEFT, 20, 1'b0, 1'b0, 3'd0, 3'd0); idle(10);
      press(M_LEFT, 20, 1'b1, 1'b0, 3'd0, 3'd1); idle(10);

      // Down to 2, long hold to 3, then wrap to 0.
      press(M_DOWN,  20, 1'b1, 1'b0, 3'd0, 3'd2); idle(10);
      press(M_DOWN, 100, 1'b1, 1'b0, 3'd0, 3'd3); idle(10);
      press(M_DOWN,  20, 1'b1, 1'b0, 3'd0, 3'd0); idle(20);

      check("sb_pending", sb.size(), 0);
      check("final_mdc", int'(mdc), 0);
      check("final_mdl", int'(mdl), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
